// File: rtl/bcd_counter_pkg.sv
// Shared definitions for the BCD counter: digit width, terminal value and digit type.
// Optional parallel load is enabled with the BCD_COUNTER_LOAD_EN macro.
package bcd_counter_pkg;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    function automatic logic is_terminal(input bcd_digit_t d);
        return d == BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit cell: increments when enabled with carry-in, wraps 9 (or any
// illegal 10-15) to 0 and raises a ripple carry. Load port exists with BCD_COUNTER_LOAD_EN.
module bcd_digit
    import bcd_counter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       cin,
`ifdef BCD_COUNTER_LOAD_EN
    input  logic       load,
    input  bcd_digit_t din,
`endif
    output bcd_digit_t q,
    output logic       co
);

    bcd_digit_t q_d;
    bcd_digit_t q_q;
    logic       wrap;
    logic       inc;

    // Values at or above 9 wrap to 0, so a loaded illegal value also carries.
    always_comb begin
        wrap = (q_q >= BCD_MAX);
        inc  = en && cin;
        q_d  = q_q;
`ifdef BCD_COUNTER_LOAD_EN
        if (load) begin
            q_d = din;
        end else if (inc) begin
            q_d = wrap ? '0 : q_q + 4'd1;
        end
`else
        if (inc) begin
            q_d = wrap ? '0 : q_q + 4'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign co = inc && wrap;

endmodule

// File: rtl/bcd_counter.sv
// Cascadable DIGITS-wide BCD counter (DIGITS 1-8) built from chained bcd_digit cells.
// Defining BCD_COUNTER_LOAD_EN adds the load/din parallel-load ports.
module bcd_counter
    import bcd_counter_pkg::*;
#(
    parameter int DIGITS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
`ifdef BCD_COUNTER_LOAD_EN
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
`endif
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  cout
);

    logic [DIGITS:0]   carry;
    logic [DIGITS-1:0] nine;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .cin  (carry[i]),
`ifdef BCD_COUNTER_LOAD_EN
            .load (load),
            .din  (din[BCD_W*i +: BCD_W]),
`endif
            .q    (bcd[BCD_W*i +: BCD_W]),
            .co   (carry[i+1])
        );

        assign nine[i] = is_terminal(bcd[BCD_W*i +: BCD_W]);
    end

    // The final ripple carry already includes en; the all-nines term keeps
    // loaded illegal digits from raising cout.
    assign cout = carry[DIGITS] & (&nine);

endmodule

// File: tb/tb_bcd_counter.sv
// Self-checking bench for bcd_counter: one- and two-digit instances against an integer model.
// Load behaviour is exercised when BCD_COUNTER_LOAD_EN is defined.
module tb_bcd_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       load;
    logic [3:0] din1;
    logic [7:0] din2;
    logic [3:0] bcd1;
    logic [7:0] bcd2;
    logic       cout1;
    logic       cout2;

    int cnt1;
    int cnt2;
    bit model_valid = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bcd_counter #(.DIGITS(1)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
`ifdef BCD_COUNTER_LOAD_EN
        .load (load),
        .din  (din1),
`endif
        .bcd  (bcd1),
        .cout (cout1)
    );

    bcd_counter #(.DIGITS(2)) dut2 (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
`ifdef BCD_COUNTER_LOAD_EN
        .load (load),
        .din  (din2),
`endif
        .bcd  (bcd2),
        .cout (cout2)
    );

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int          t;
        r = '0;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [31:0] b, input int nd);
        int v;
        int s;
        v = 0;
        s = 1;
        for (int i = 0; i < nd; i++) begin
            v = v + s * int'(b[4*i +: 4]);
            s = s * 10;
        end
        return v;
    endfunction

    task automatic checkOutput(input string tag);
        logic [31:0] e1;
        logic [31:0] e2;
        logic        ec1;
        logic        ec2;
        if (model_valid) begin
            e1  = to_bcd(cnt1);
            e2  = to_bcd(cnt2);
            ec1 = (en === 1'b1) && (cnt1 == 9);
            ec2 = (en === 1'b1) && (cnt2 == 99);
            vectors += 4;
            assert (bcd1 === e1[3:0]) else begin
                miscompares++;
                $error("[TB] FAIL %s bcd1: got %h expected %h", tag, bcd1, e1[3:0]);
            end
            assert (cout1 === ec1) else begin
                miscompares++;
                $error("[TB] FAIL %s cout1: got %b expected %b", tag, cout1, ec1);
            end
            assert (bcd2 === e2[7:0]) else begin
                miscompares++;
                $error("[TB] FAIL %s bcd2: got %h expected %h", tag, bcd2, e2[7:0]);
            end
            assert (cout2 === ec2) else begin
                miscompares++;
                $error("[TB] FAIL %s cout2: got %b expected %b", tag, cout2, ec2);
            end
        end
    endtask

    // Drive one cycle of inputs, check pre-edge outputs, then advance the model.
    task automatic applyStimulus(input logic r, input logic e, input logic l,
                                 input logic [7:0] d, input string tag);
        @(negedge clk);
        rst  = r;
        en   = e;
        load = l;
        din1 = d[3:0];
        din2 = d;
        #1;
        checkOutput(tag);
        @(posedge clk);
        if (r === 1'b1) begin
            cnt1 = 0;
            cnt2 = 0;
            model_valid = 1'b1;
`ifdef BCD_COUNTER_LOAD_EN
        end else if (l === 1'b1) begin
            cnt1 = from_bcd({28'd0, d[3:0]}, 1);
            cnt2 = from_bcd({24'd0, d}, 2);
`endif
        end else if (e === 1'b1) begin
            cnt1 = (cnt1 + 1) % 10;
            cnt2 = (cnt2 + 1) % 100;
        end
    endtask

    initial begin
        logic [7:0] rd;
        rst  = 1'b0;
        en   = 1'bx;
        load = 1'b0;
        din1 = '0;
        din2 = '0;

        applyStimulus(1'b1, 1'bx, 1'b0, 8'h00, "reset_xen");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, "reset_en");

        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "count15");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, "midreset");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "resume");

        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "to3");
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, "hold3");
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "to9");
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, "nine_noen");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, "nine_rst_en");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "fresh");

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, "reset2");
        for (int i = 0; i < 99; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "to99");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "wrap99");
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, "after_wrap");

`ifdef BCD_COUNTER_LOAD_EN
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h47, "load47_en");
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h47, "load47_noen");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "after_load");
`endif

        for (int i = 0; i < 400; i++) begin
            rd[7:4] = 4'($urandom_range(0, 9));
            rd[3:0] = 4'($urandom_range(0, 9));
            applyStimulus(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
`ifdef BCD_COUNTER_LOAD_EN
                          ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0,
`else
                          1'b0,
`endif
                          rd, "random");
        end

        @(negedge clk);
        rst  = 1'b0;
        en   = 1'b0;
        load = 1'b0;
        #1;
        checkOutput("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
